// File: rtl/bcd_calc_sequencer.sv
// Key-entry sequencer for a 3-digit signed BCD calculator. Collects operands A and B
// from a keypad, drives an external add/sub datapath and latches its result for display.
module bcd_calc_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic [11:0] A,
  output logic [11:0] B,
  output logic        Asign,
  output logic        Bsign,
  output logic        Mode,
  input  logic [11:0] Out,
  input  logic        Sign,
  input  logic        Cout,
  output logic [11:0] disp,
  output logic        disp_sign,
  output logic        ovf,
  output logic        result_valid
);

  localparam logic [3:0] KeyPlus   = 4'hA;
  localparam logic [3:0] KeyMinus  = 4'hB;
  localparam logic [3:0] KeyEquals = 4'hC;
  localparam logic [3:0] KeyClear  = 4'hD;
  localparam logic [3:0] KeyNegate = 4'hE;

  typedef enum logic [1:0] {StEntA, StEntB, StExec, StShow} state_e;

  state_e      state_q, state_d;
  logic [11:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]  acnt_q, acnt_d, bcnt_q, bcnt_d;
  logic        asign_q, asign_d, bsign_q, bsign_d, mode_q, mode_d;
  logic        res_sign_q, res_sign_d, ovf_q, ovf_d, rv_q, rv_d;

  logic key_fire, is_digit, is_op, is_clear, op_mode;

  assign key_fire = key_valid && key_ready;
  assign is_digit = key_code <= 4'd9;
  assign is_op    = (key_code == KeyPlus) || (key_code == KeyMinus);
  assign is_clear = key_code == KeyClear;
  assign op_mode  = key_code == KeyMinus;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEntA;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= 12'h000;
      b_q        <= 12'h000;
      res_q      <= 12'h000;
      acnt_q     <= 2'd0;
      bcnt_q     <= 2'd0;
      asign_q    <= 1'b0;
      bsign_q    <= 1'b0;
      mode_q     <= 1'b0;
      res_sign_q <= 1'b0;
      ovf_q      <= 1'b0;
      rv_q       <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      acnt_q     <= acnt_d;
      bcnt_q     <= bcnt_d;
      asign_q    <= asign_d;
      bsign_q    <= bsign_d;
      mode_q     <= mode_d;
      res_sign_q <= res_sign_d;
      ovf_q      <= ovf_d;
      rv_q       <= rv_d;
    end
  end

  // Next-state logic: EXEC always lasts one cycle, keys only move the FSM when accepted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEntA: begin
        if (key_fire && is_clear)   state_d = StEntA;
        else if (key_fire && is_op) state_d = StEntB;
      end
      StEntB: begin
        if (key_fire && is_clear)                       state_d = StEntA;
        else if (key_fire && key_code == KeyEquals)     state_d = StExec;
      end
      StExec: state_d = StShow;
      StShow: begin
        if (key_fire && (is_clear || is_digit)) state_d = StEntA;
        else if (key_fire && is_op)             state_d = StEntB;
      end
      default: state_d = StEntA;
    endcase
  end

  // Operand / result register updates driven by accepted keys and the EXEC cycle
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    acnt_d     = acnt_q;
    bcnt_d     = bcnt_q;
    asign_d    = asign_q;
    bsign_d    = bsign_q;
    mode_d     = mode_q;
    res_sign_d = res_sign_q;
    ovf_d      = ovf_q;
    rv_d       = 1'b0;
    if (key_fire && is_clear) begin
      a_d        = 12'h000;
      b_d        = 12'h000;
      res_d      = 12'h000;
      acnt_d     = 2'd0;
      bcnt_d     = 2'd0;
      asign_d    = 1'b0;
      bsign_d    = 1'b0;
      mode_d     = 1'b0;
      res_sign_d = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      unique case (state_q)
        StEntA: begin
          if (key_fire && is_digit) begin
            if (acnt_q < 2'd3) begin
              a_d    = {a_q[7:0], key_code};
              acnt_d = acnt_q + 2'd1;
            end
          end else if (key_fire && key_code == KeyNegate) begin
            asign_d = ~asign_q;
          end else if (key_fire && is_op) begin
            mode_d  = op_mode;
            b_d     = 12'h000;
            bsign_d = 1'b0;
            bcnt_d  = 2'd0;
          end
        end
        StEntB: begin
          if (key_fire && is_digit) begin
            if (bcnt_q < 2'd3) begin
              b_d    = {b_q[7:0], key_code};
              bcnt_d = bcnt_q + 2'd1;
            end
          end else if (key_fire && key_code == KeyNegate) begin
            bsign_d = ~bsign_q;
          end else if (key_fire && is_op) begin
            mode_d = op_mode;
          end
        end
        StExec: begin
          res_d      = Out;
          // A zero magnitude is never shown as negative
          res_sign_d = Sign && (Out != 12'h000);
          ovf_d      = ovf_q | Cout;
          rv_d       = 1'b1;
        end
        StShow: begin
          if (key_fire && is_digit) begin
            a_d     = {8'h00, key_code};
            acnt_d  = 2'd1;
            asign_d = 1'b0;
            b_d     = 12'h000;
            bcnt_d  = 2'd0;
            bsign_d = 1'b0;
            mode_d  = 1'b0;
            ovf_d   = 1'b0;
          end else if (key_fire && is_op) begin
            // Chain: the last result becomes a full 3-digit operand A
            a_d     = res_q;
            asign_d = res_sign_q;
            acnt_d  = 2'd3;
            mode_d  = op_mode;
            b_d     = 12'h000;
            bsign_d = 1'b0;
            bcnt_d  = 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: the display follows the operand being entered, or the latched result
  always_comb begin
    key_ready    = state_q != StExec;
    A            = a_q;
    B            = b_q;
    Asign        = asign_q;
    Bsign        = bsign_q;
    Mode         = mode_q;
    ovf          = ovf_q;
    result_valid = rv_q;
    disp         = res_q;
    disp_sign    = res_sign_q;
    unique case (state_q)
      StEntA: begin
        disp      = a_q;
        disp_sign = asign_q;
      end
      StEntB, StExec: begin
        disp      = b_q;
        disp_sign = bsign_q;
      end
      StShow: begin
        disp      = res_q;
        disp_sign = res_sign_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bcd_calc_sequencer.sv
// Bench for bcd_calc_sequencer: emulates the add/sub datapath and checks against a
// key-event model that keeps operands as plain integers.
module tb_bcd_calc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [11:0] A, B, dp_out, disp;
  logic        Asign, Bsign, Mode, dp_sign, dp_cout, disp_sign, ovf, result_valid;

  // Forced datapath response, used to present a negative zero
  logic        ovr_en;
  logic [11:0] ovr_out;
  logic        ovr_sign, ovr_cout;
  logic [13:0] dp;

  int n_cmp = 0;
  int n_err = 0;

  localparam int EntA = 0;
  localparam int EntB = 1;
  localparam int Exec = 2;
  localparam int Show = 3;

  int m_st, m_a, m_b, m_acnt, m_bcnt, m_res;
  bit m_as, m_bs, m_mode, m_rs, m_ovf, m_rv;

  bcd_calc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .A            (A),
    .B            (B),
    .Asign        (Asign),
    .Bsign        (Bsign),
    .Mode         (Mode),
    .Out          (dp_out),
    .Sign         (dp_sign),
    .Cout         (dp_cout),
    .disp         (disp),
    .disp_sign    (disp_sign),
    .ovf          (ovf),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [11:0] v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // Signed decimal add/sub: {overflow, sign, 3-digit magnitude}
  function automatic logic [13:0] dp_calc(input logic [11:0] a, input logic [11:0] b,
                                          input logic as, input logic bs, input logic m);
    int va, vb, r, mag;
    va  = as ? -bcd2int(a) : bcd2int(a);
    vb  = bs ? -bcd2int(b) : bcd2int(b);
    r   = m ? va - vb : va + vb;
    mag = (r < 0) ? -r : r;
    return {mag > 999, r < 0, int2bcd(mag % 1000)};
  endfunction

  always_comb begin
    dp = dp_calc(A, B, Asign, Bsign, Mode);
    if (ovr_en) dp = {ovr_cout, ovr_sign, ovr_out};
  end
  assign dp_out  = dp[11:0];
  assign dp_sign = dp[12];
  assign dp_cout = dp[13];

  task automatic model_reset();
    m_st = EntA; m_a = 0; m_b = 0; m_acnt = 0; m_bcnt = 0; m_res = 0;
    m_as = 0; m_bs = 0; m_mode = 0; m_rs = 0; m_ovf = 0; m_rv = 0;
  endtask

  // One clock edge of the reference behaviour, using the key presented before it
  task automatic model_edge(input bit v, input logic [3:0] k);
    logic [13:0] r;
    int          kd;
    bit          fire;
    kd   = int'(k);
    fire = v && (m_st != Exec);
    m_rv = 0;
    if (m_st == Exec) begin
      if (ovr_en) r = {ovr_cout, ovr_sign, ovr_out};
      else r = dp_calc(int2bcd(m_a), int2bcd(m_b), m_as, m_bs, m_mode);
      m_res = bcd2int(r[11:0]);
      m_rs  = r[12] && (m_res != 0);
      m_ovf = m_ovf | r[13];
      m_rv  = 1;
      m_st  = Show;
    end else if (fire && kd == 13) begin
      model_reset();
    end else if (fire) begin
      case (m_st)
        EntA: begin
          if (kd <= 9) begin
            if (m_acnt < 3) begin m_a = m_a * 10 + kd; m_acnt++; end
          end else if (kd == 14) m_as = !m_as;
          else if (kd == 10 || kd == 11) begin
            m_mode = (kd == 11); m_b = 0; m_bs = 0; m_bcnt = 0; m_st = EntB;
          end
        end
        EntB: begin
          if (kd <= 9) begin
            if (m_bcnt < 3) begin m_b = m_b * 10 + kd; m_bcnt++; end
          end else if (kd == 14) m_bs = !m_bs;
          else if (kd == 10 || kd == 11) m_mode = (kd == 11);
          else if (kd == 12) m_st = Exec;
        end
        Show: begin
          if (kd <= 9) begin
            m_a = kd; m_acnt = 1; m_as = 0; m_b = 0; m_bcnt = 0; m_bs = 0;
            m_mode = 0; m_ovf = 0; m_st = EntA;
          end else if (kd == 10 || kd == 11) begin
            m_a = m_res; m_as = m_rs; m_acnt = 3; m_mode = (kd == 11);
            m_b = 0; m_bs = 0; m_bcnt = 0; m_st = EntB;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("key_ready", 32'(key_ready), 32'(m_st != Exec));
    check("A", 32'(A), 32'(int2bcd(m_a)));
    check("B", 32'(B), 32'(int2bcd(m_b)));
    check("Asign", 32'(Asign), 32'(m_as));
    check("Bsign", 32'(Bsign), 32'(m_bs));
    check("Mode", 32'(Mode), 32'(m_mode));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("result_valid", 32'(result_valid), 32'(m_rv));
    if (m_st == EntA) begin
      check("disp", 32'(disp), 32'(int2bcd(m_a)));
      check("disp_sign", 32'(disp_sign), 32'(m_as));
    end else if (m_st == EntB) begin
      check("disp", 32'(disp), 32'(int2bcd(m_b)));
      check("disp_sign", 32'(disp_sign), 32'(m_bs));
    end else if (m_st == Show) begin
      check("disp", 32'(disp), 32'(int2bcd(m_res)));
      check("disp_sign", 32'(disp_sign), 32'(m_rs));
    end
  endtask

  // Called at posedge+1: present a key for one cycle, then check after the edge
  task automatic step(input bit v, input logic [3:0] k);
    key_valid = v;
    key_code  = k;
    check("key_ready_pre", 32'(key_ready), 32'(m_st != Exec));
    @(posedge clk);
    model_edge(v, k);
    #1;
    key_valid = 1'b0;
    check_all();
  endtask

  task automatic press(input logic [3:0] k);
    step(1'b1, k);
  endtask

  // Reset pulse placed between clock edges; outputs must clear without an edge
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] k;
    bit         v;
    rst_n     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    ovr_en    = 1'b0;
    ovr_out   = 12'h000;
    ovr_sign  = 1'b0;
    ovr_cout  = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Simple add
    press(4'h1); press(4'h2); press(4'h3); press(4'hA);
    press(4'h4); press(4'h5); press(4'h6);
    check("add_A", 32'(A), 32'h123);
    check("add_B", 32'(B), 32'h456);
    check("add_Mode", 32'(Mode), 32'h0);
    press(4'hC);
    check("exec_ready", 32'(key_ready), 32'h0);
    step(1'b0, 4'h0);
    check("add_disp", 32'(disp), 32'h579);
    check("add_sign", 32'(disp_sign), 32'h0);
    check("add_rv", 32'(result_valid), 32'h1);
    step(1'b0, 4'h0);
    check("add_rv_once", 32'(result_valid), 32'h0);

    // Negative result
    press(4'hD); press(4'h5); press(4'hB); press(4'h8); press(4'hC);
    check("neg_exec_ready", 32'(key_ready), 32'h0);
    step(1'b0, 4'h0);
    check("neg_disp", 32'(disp), 32'h003);
    check("neg_sign", 32'(disp_sign), 32'h1);
    check("neg_ready", 32'(key_ready), 32'h1);

    // Digit limit and negate
    press(4'hD); press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'hE);
    check("lim_A", 32'(A), 32'h987);
    check("lim_Asign", 32'(Asign), 32'h1);

    // Chaining and overflow
    press(4'hD); press(4'h9); press(4'h9); press(4'h9); press(4'hA); press(4'h0);
    press(4'hC); step(1'b0, 4'h0);
    check("chain_res", 32'(disp), 32'h999);
    press(4'hA);
    check("chain_A", 32'(A), 32'h999);
    check("chain_B", 32'(B), 32'h000);
    press(4'h1); press(4'hC); step(1'b0, 4'h0);
    check("ovf_set", 32'(ovf), 32'h1);
    check("ovf_disp", 32'(disp), 32'h000);
    press(4'h7);
    check("ovf_clr", 32'(ovf), 32'h0);
    check("new_A", 32'(A), 32'h007);

    // Zero magnitude reported with a negative sign
    press(4'hD); press(4'h1); press(4'hA); press(4'h2);
    ovr_en = 1'b1; ovr_out = 12'h000; ovr_sign = 1'b1; ovr_cout = 1'b0;
    press(4'hC); step(1'b0, 4'h0);
    check("zero_sign", 32'(disp_sign), 32'h0);
    ovr_en = 1'b0;

    // Key held during EXEC is dropped
    press(4'hD); press(4'h4); press(4'hA); press(4'h2); press(4'hC);
    step(1'b1, 4'h5);
    check("drop_A", 32'(A), 32'h004);
    check("drop_rv", 32'(result_valid), 32'h1);
    check("drop_disp", 32'(disp), 32'h006);

    // Async reset mid-entry and during EXEC
    press(4'h3); press(4'h1);
    async_reset();
    check("rst_A", 32'(A), 32'h000);
    check("rst_disp", 32'(disp), 32'h000);
    press(4'h2); press(4'hB); press(4'h1); press(4'hC);
    async_reset();
    step(1'b0, 4'h0);
    check("rst_exec_rv", 32'(result_valid), 32'h0);
    check("rst_exec_ready", 32'(key_ready), 32'h1);

    // Randomized key stream
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 7) != 0);
      k = 4'($urandom_range(0, 15));
      if (k == 4'hD && $urandom_range(0, 3) != 0) k = 4'hC;
      if (i == 250) async_reset();
      step(v, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_calc_sequencer.md
BCD_CALC_SEQUENCER -- requirements
Module: bcd_calc_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk (rising edge) and rst_n.
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- key_valid  in  1  key strobe, one cycle per key
- key_code  in  4  0-9 digit; 4'hA plus; 4'hB minus; 4'hC equals; 4'hD clear; 4'hE negate
- key_ready  out  1  key accepted this cycle when key_valid && key_ready
- A  out  12  3-digit BCD operand A to the add/sub datapath
- B  out  12  3-digit BCD operand B to the datapath
- Asign  out  1  sign of A (1 = negative)
- Bsign  out  1  sign of B
- Mode  out  1  0 add, 1 subtract
- Out  in  12  datapath BCD magnitude result (combinational from A/B/signs/Mode)
- Sign  in  1  datapath result sign
- Cout  in  1  datapath overflow indication
- disp  out  12  BCD magnitude shown to the user
- disp_sign  out  1  displayed sign
- ovf  out  1  sticky overflow flag
- result_valid  out  1  one-cycle pulse when a result is latched

Function
REQ-003 The FSM SHALL have states ENT_A, ENT_B, EXEC, SHOW; the reset state SHALL be ENT_A.
REQ-004 key_ready SHALL be 1 in ENT_A, ENT_B and SHOW, and 0 in EXEC; keys presented while key_ready = 0 SHALL be dropped.
REQ-005 A digit key in ENT_A SHALL shift A left one BCD digit and insert the digit at A[3:0], only while the A digit count < 3; further digits SHALL be ignored.
REQ-006 The same digit rule SHALL apply to B in ENT_B, using B's own digit count.
REQ-007 Negate SHALL toggle Asign in ENT_A and Bsign in ENT_B; in SHOW it SHALL be ignored.
REQ-008 Plus or minus in ENT_A SHALL set Mode (plus 0, minus 1), clear B, Bsign and B's digit count, and move to ENT_B.
REQ-009 Plus or minus in ENT_B SHALL update Mode only, with no state change.
REQ-010 Equals in ENT_B SHALL move to EXEC; equals in ENT_A or SHOW SHALL be ignored.
REQ-011 EXEC SHALL last exactly one cycle, holding A, B, Asign, Bsign and Mode stable. On its clock edge the block SHALL:
- latch disp <= Out and disp_sign <= Sign;
- set ovf <= ovf | Cout;
- pulse result_valid for exactly the following cycle;
- enter SHOW.
REQ-012 A result of zero magnitude SHALL force disp_sign to 0.
REQ-013 A digit key in SHOW SHALL start a new calculation:
- clear A, Asign, B, Bsign, Mode and ovf;
- load the digit as A's first digit (A digit count = 1);
- enter ENT_A.
REQ-014 Plus or minus in SHOW SHALL chain from the last result:
- load A <= disp and Asign <= disp_sign, with A digit count 3;
- set Mode per the key;
- clear B, Bsign and B's digit count;
- enter ENT_B.
REQ-015 Clear SHALL act from ENT_A, ENT_B or SHOW: reset every register to its reset value and enter ENT_A.
REQ-016 While in ENT_A or ENT_B, disp SHALL show the operand being entered (A or B) and disp_sign its sign; in SHOW, disp and disp_sign SHALL hold the latched result.
REQ-017 Undefined codes 4'hF SHALL be ignored in all states.
REQ-018 All state changes SHALL occur on the rising edge of clk; keys SHALL be processed one per cycle, with no internal buffering.

Reset
REQ-019 On rst_n low, asynchronously: state = ENT_A; A, B, disp = 12'h000; Asign, Bsign, Mode, disp_sign, ovf, result_valid = 0; both digit counts = 0; key_ready = 1 once in ENT_A.
REQ-020 Reset asserted during EXEC SHALL abort the operation with no result_valid pulse.

Verification
REQ-021 Simple add: keys 1,2,3,+,4,5,6,= -> A = 12'h123, B = 12'h456, Mode = 0; one cycle after EXEC, disp = 12'h579, disp_sign = 0, result_valid a single pulse.
REQ-022 Negative result: keys 5,-,8,= with the datapath returning Out = 12'h003, Sign = 1 -> disp = 12'h003, disp_sign = 1; key_ready = 0 only during the EXEC cycle.
REQ-023 Digit limit and negate: keys 9,8,7,6,E -> A = 12'h987 (the fourth digit is dropped), Asign = 1.
REQ-024 Chaining and overflow: result 12'h999 then keys +,1,= with Cout = 1 -> A = 12'h999 entering ENT_B, ovf = 1 after EXEC; a subsequent digit key clears ovf.
REQ-025 Dropped key and async reset: key_valid held during EXEC -> key ignored; rst_n pulsed low mid-entry -> all outputs at reset values immediately, without waiting for a clock edge.
